// File: rtl/bwm_arbiter.sv
// bwm_arbiter: two-requester arbiter sharing one 4x4 Baugh-Wooley signed multiplier
// Ports: clk; rst async active-high; req0/req1 with operands a0/b0, a1/b1;
//   gnt0/gnt1 grants (operands captured on the edge where gnt is high);
//   p/p_valid/p_id product handshake closed by p_ready; busy when FSM not IDLE.
// PRIO_FIXED: 0 round-robin, 1 requester 0 wins ties.
// BWM_PIPE_EN: registers the multiplier after the second partial-product row (adds CALC2).
module bwm_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] p,
  output logic       p_valid,
  output logic       p_id,
  input  logic       p_ready,
  output logic       busy
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
`ifdef BWM_PIPE_EN
    CALC2,
`endif
    DONE
  } state_t;
  state_t state, nxt;
  logic [3:0] a_r, b_r;
  logic id_r, last, win1;
  logic [7:0] pp_lo, pp_hi;
`ifdef BWM_PIPE_EN
  logic [7:0] lo_r;
`endif
  // Row i of the Baugh-Wooley array: sign-position terms complemented, except a3&b3.
  function automatic logic [7:0] bw_row(input logic [3:0] x, input logic [3:0] y, input logic [1:0] i);
    logic [3:0] r;
    r = x & {4{y[i]}};
    r = (i == 2'd3) ? {r[3], ~r[2:0]} : {~r[3], r[2:0]};
    return 8'(r) << i;
  endfunction
  // 8'h90 folds in the Baugh-Wooley correction constants 2^4 + 2^7.
  assign pp_lo = bw_row(a_r, b_r, 2'd0) + bw_row(a_r, b_r, 2'd1) + 8'h90;
  assign pp_hi = bw_row(a_r, b_r, 2'd2) + bw_row(a_r, b_r, 2'd3);
  // last holds the index granted most recently; on a round-robin tie the other one wins.
  assign win1 = req1 && (!req0 || (PRIO_FIXED == 0 && !last));
  assign gnt0 = !rst && state == IDLE && req0 && !win1;
  assign gnt1 = !rst && state == IDLE && win1;
  assign busy = state != IDLE;
  assign p_valid = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (req0 || req1) ? CALC : IDLE;
`ifdef BWM_PIPE_EN
      CALC: nxt = CALC2;
      CALC2: nxt = DONE;
`else
      CALC: nxt = DONE;
`endif
      DONE: nxt = p_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      id_r <= 1'b0;
      last <= 1'b1;
      p <= '0;
      p_id <= 1'b0;
`ifdef BWM_PIPE_EN
      lo_r <= '0;
`endif
    end else begin
      state <= nxt;
      if (gnt0 || gnt1) begin
        a_r <= gnt1 ? a1 : a0;
        b_r <= gnt1 ? b1 : b0;
        id_r <= gnt1;
        last <= gnt1;
      end
`ifdef BWM_PIPE_EN
      if (state == CALC) lo_r <= pp_lo;
      if (state == CALC2) begin
        p <= lo_r + pp_hi;
        p_id <= id_r;
      end
`else
      if (state == CALC) begin
        p <= pp_lo + pp_hi;
        p_id <= id_r;
      end
`endif
    end
  end
endmodule

// File: tb/tb_bwm_arbiter.sv
// tb_bwm_arbiter: directed vectors, corner sequences and randomized model check for bwm_arbiter
module tb_bwm_arbiter;
`ifdef BWM_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst, req0, req1, p_ready;
  logic [3:0] a0, b0, a1, b1;
  logic gnt0, gnt1, p_valid, p_id, busy;
  logic [7:0] p;
  logic gnt0_f, gnt1_f, p_valid_f, p_id_f, busy_f;
  logic [7:0] p_f;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;
  vec_t vecs[10];
  int ph;
  bit m_last, m_id, pend_id, pend0, pend1, take0, take1, w, any, e_g0, e_g1;
  logic [7:0] m_p, pend_p;
  always #5 clk = ~clk;
  bwm_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .p(p), .p_valid(p_valid), .p_id(p_id), .p_ready(p_ready), .busy(busy)
  );
  bwm_arbiter #(.PRIO_FIXED(1)) dut_f (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0_f), .gnt1(gnt1_f), .p(p_f), .p_valid(p_valid_f), .p_id(p_id_f), .p_ready(p_ready), .busy(busy_f)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic nxt_cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    p_ready = 1'b1;
    nxt_cyc();
    nxt_cyc();
    rst = 1'b0;
  endtask
  function automatic logic [7:0] mul(input logic [3:0] x, input logic [3:0] y);
    int r;
    r = $signed(x) * $signed(y);
    return r[7:0];
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b0, 4'h3, 4'h5, 8'h0F};
    vecs[1] = '{1'b0, 4'h8, 4'h8, 8'h40};
    vecs[2] = '{1'b1, 4'h7, 4'h8, 8'hC8};
    vecs[3] = '{1'b0, 4'hF, 4'h1, 8'hFF};
    vecs[4] = '{1'b1, 4'h0, 4'h7, 8'h00};
    vecs[5] = '{1'b1, 4'hF, 4'hF, 8'h01};
    vecs[6] = '{1'b0, 4'h7, 4'h7, 8'h31};
    vecs[7] = '{1'b1, 4'h5, 4'hD, 8'hF1};
    vecs[8] = '{1'b0, 4'hF, 4'h8, 8'h08};
    vecs[9] = '{1'b1, 4'h6, 4'h9, 8'hD6};
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; p_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1 rst = 1'b1;
    req0 = 1'b1; a0 = 4'h3; b0 = 4'h5;
    #2;
    chk("reset_outs", {gnt0, gnt1, busy, p_valid, p_id, p}, 16'h0);
    chk("reset_outs_fp", {gnt0_f, gnt1_f, busy_f, p_valid_f, p_id_f, p_f}, 16'h0);
    nxt_cyc();
    req0 = 1'b0;
    rst = 1'b0;
    #3;
    chk("rst_no_capture", {busy, p_valid}, 16'h0);
    foreach (vecs[i]) begin
      nxt_cyc();
      req0 = !vecs[i].id; req1 = vecs[i].id;
      a0 = vecs[i].a; b0 = vecs[i].b; a1 = vecs[i].a; b1 = vecs[i].b;
      #3;
      chk($sformatf("vec%0d_gnt", i), {gnt0, gnt1}, vecs[i].id ? 16'b01 : 16'b10);
      for (int j = 1; j < LAT; j++) begin
        nxt_cyc();
        req0 = 1'b0; req1 = 1'b0;
        #3;
        chk($sformatf("vec%0d_calc", i), {gnt0, gnt1, busy, p_valid}, 16'b0010);
      end
      nxt_cyc();
      #3;
      chk($sformatf("vec%0d_done", i), {p_valid, p_id, p}, {1'b1, vecs[i].id, vecs[i].p});
      nxt_cyc();
      #3;
      chk($sformatf("vec%0d_retain", i), {busy, p_valid, p}, {2'b00, vecs[i].p});
    end
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'h2; b0 = 4'h3; a1 = 4'hE; b1 = 4'h5;
    for (int t = 0; t < 4; t++) begin
      #3;
      chk($sformatf("cont%0d_gnt", t), {gnt0, gnt1}, (t % 2) ? 16'b01 : 16'b10);
      chk($sformatf("fp%0d_gnt", t), {gnt0_f, gnt1_f}, 16'b10);
      for (int j = 1; j < LAT; j++) begin
        nxt_cyc();
        #3;
        chk("cont_wait", {gnt0, gnt1, gnt0_f, gnt1_f}, 16'h0);
      end
      nxt_cyc();
      #3;
      chk($sformatf("cont%0d_done", t), {p_valid, p_id, p}, (t % 2) ? {1'b1, 1'b1, 8'hF6} : {1'b1, 1'b0, 8'h06});
      chk($sformatf("fp%0d_done", t), {p_valid_f, p_id_f, p_f}, {1'b1, 1'b0, 8'h06});
      nxt_cyc();
    end
    do_reset();
    req0 = 1'b1; a0 = 4'h7; b0 = 4'h7;
    #3;
    chk("bp_gnt", {gnt0, gnt1}, 16'b10);
    for (int j = 1; j < LAT; j++) begin
      nxt_cyc();
      req0 = 1'b0; p_ready = 1'b0;
      req1 = 1'b1; a1 = 4'h1; b1 = 4'h1;
      #3;
      chk("bp_calc", {gnt0, gnt1, busy}, 16'b001);
    end
    for (int k = 0; k < 5; k++) begin
      nxt_cyc();
      #3;
      chk($sformatf("bp_hold%0d", k), {gnt0, gnt1, p_valid, p_id, p}, {3'b001, 1'b0, 8'h31});
    end
    nxt_cyc();
    p_ready = 1'b1;
    #3;
    chk("bp_release", {gnt0, gnt1, p_valid, p}, {3'b001, 8'h31});
    nxt_cyc();
    #3;
    chk("bp_next_gnt", {p_valid, busy, gnt0, gnt1, p}, {4'b0001, 8'h31});
    nxt_cyc();
    req1 = 1'b0;
    #3;
    chk("bp_next_busy", {busy, p_valid}, 16'b10);
    do_reset();
    req1 = 1'b1; a1 = 4'h5; b1 = 4'h5;
    #3;
    chk("mr_gnt1", {gnt0, gnt1}, 16'b01);
    for (int j = 1; j < LAT; j++) begin
      nxt_cyc();
      req1 = 1'b0;
    end
    nxt_cyc();
    #3;
    chk("mr_done", {p_valid, p_id, p}, {1'b1, 1'b1, 8'h19});
    nxt_cyc();
    req0 = 1'b1; a0 = 4'h3; b0 = 4'h3;
    #3;
    chk("mr_gnt0", {gnt0, gnt1}, 16'b10);
    nxt_cyc();
    req0 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mr_async", {busy, p_valid, p_id, p, gnt0, gnt1}, 16'h0);
    nxt_cyc();
    nxt_cyc();
    rst = 1'b0;
    for (int j = 0; j <= LAT; j++) begin
      #3;
      chk("mr_no_valid", {busy, p_valid, p}, 16'h0);
      nxt_cyc();
    end
    req0 = 1'b1; req1 = 1'b1;
    #3;
    chk("mr_tie", {gnt0, gnt1}, 16'b10);
    nxt_cyc();
    do_reset();
    ph = 0; m_last = 1'b1; m_id = 1'b0; m_p = '0;
    pend0 = 1'b0; pend1 = 1'b0; take0 = 1'b0; take1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (take0) begin pend0 = 1'b0; req0 = 1'b0; end
      if (take1) begin pend1 = 1'b0; req1 = 1'b0; end
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
      end else if (pend0 && $urandom_range(0, 9) == 0) begin
        pend0 = 1'b0; req0 = 1'b0;
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom);
      end else if (pend1 && $urandom_range(0, 9) == 0) begin
        pend1 = 1'b0; req1 = 1'b0;
      end
      p_ready = $urandom_range(0, 3) != 0;
      #3;
      any = req0 || req1;
      w = (req0 && req1) ? !m_last : req1;
      e_g0 = ph == 0 && any && !w;
      e_g1 = ph == 0 && any && w;
      chk($sformatf("rand%0d", c), {gnt0, gnt1, busy, p_valid, p_id, p},
          {e_g0, e_g1, ph != 0, ph == LAT, m_id, m_p});
      if (ph == 0) begin
        if (any) begin
          ph = 1;
          m_last = w;
          pend_id = w;
          pend_p = w ? mul(a1, b1) : mul(a0, b0);
        end
      end else if (ph < LAT) begin
        ph++;
        if (ph == LAT) begin
          m_p = pend_p;
          m_id = pend_id;
        end
      end else if (p_ready) begin
        ph = 0;
      end
      take0 = e_g0;
      take1 = e_g1;
      nxt_cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
